ble_pdu_deframer: RTL

Downstream stage of the BLE receive core. It consumes the recovered bit stream (symbol, symbol strobe, packet-detected flag) produced by the clock/data-recovery block. From that stream it de-whitens the PDU using the channel index, assembles LSB-first bytes, parses the 2-byte header length, and checks CRC-24. Bytes leave through a 4-entry FIFO with a valid/ready handshake toward the byte sink or SPI/readout logic.

---
 rtl/ble_pdu_deframer.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/ble_pdu_deframer.sv
// ble_pdu_deframer
// Receive-side PDU deframer for the BLE core. It takes the recovered bit
// stream from the CDR stage, de-whitens it using the channel index, assembles
// LSB-first bytes, reads the header length, checks CRC-24, and hands bytes out
// through a small FIFO with a valid/ready handshake.
//
// Ports:
//   clk, resetn         system clock, asynchronous active-low reset
//   en                  block enable; low forces IDLE and flushes the FIFO
//   channel[5:0]        BLE channel index, seeds the whitening register
//   symbol              demodulated bit
//   symbol_clk          CDR bit clock (rising edge = new symbol)
//   packet_detected     access-address match (rising edge = PDU start)
//   byte_data[7:0]      FIFO head byte
//   byte_valid          FIFO not empty
//   byte_ready          sink accepts the head byte
//   byte_last           head byte is the final PDU byte
//   pkt_done            one-cycle pulse when the CRC comparison completes
//   crc_ok              CRC result, held until the next PDU start
//   overflow            sticky byte-drop flag, cleared at PDU start
module ble_pdu_deframer #(
    parameter logic [23:0] CRC_INIT   = 24'h555555,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       en,
    input  logic [5:0] channel,
    input  logic       symbol,
    input  logic       symbol_clk,
    input  logic       packet_detected,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    input  logic       byte_ready,
    output logic       byte_last,
    output logic       pkt_done,
    output logic       crc_ok,
    output logic       overflow
);

    localparam int            AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]   DEPTH   = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]   CNT_ONE = 1;
    localparam logic [AW-1:0] PTR_ONE = 1;

    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, CRC} state_t;

    state_t      state, state_nx;
    logic        symbol_clk_q, packet_detected_q;
    logic        sym_stb, pd_start, adv;
    logic [6:0]  w, w_nx;
    logic [23:0] crc, crc_nx;
    logic [6:0]  sreg;
    logic [7:0]  new_byte, len, byte_cnt;
    logic [4:0]  bit_cnt, crc_idx;
    logic        d, crc_match;
    logic        byte_done, hdr_done, pay_last, push, push_last;

    logic [8:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count;
    logic          full, pop, do_push, drop;

    assign sym_stb  = symbol_clk & ~symbol_clk_q;
    assign pd_start = packet_detected & ~packet_detected_q;
    // A restart in the same cycle as a strobe discards that strobe's bit.
    assign adv      = en & sym_stb & ~pd_start & (state != IDLE);

    assign d        = symbol ^ w[6];
    assign w_nx     = {w[5], w[4], w[3] ^ w[6], w[2], w[1], w[0], w[6]};
    assign crc_nx   = {crc[22:0], 1'b0} ^ ((crc[23] ^ d) ? 24'h00065B : 24'h000000);
    assign new_byte = {d, sreg};
    assign crc_idx  = 5'd23 - bit_cnt;

    assign byte_done = adv & ((state == HEADER) | (state == PAYLOAD)) & (bit_cnt[2:0] == 3'd7);
    assign hdr_done  = adv & (state == HEADER) & (bit_cnt == 5'd15);
    assign pay_last  = (byte_cnt == len - 8'd1);
    assign push      = byte_done;
    // Header byte 1 is the last byte only when the length it carries is zero.
    assign push_last = (state == HEADER) ? (bit_cnt[3] & (new_byte == 8'd0)) : pay_last;

    // Next-state logic
    always_comb begin
        state_nx = state;
        if (!en) begin
            state_nx = IDLE;
        end else if (pd_start) begin
            state_nx = HEADER;
        end else if (adv) begin
            case (state)
                HEADER:  if (hdr_done) state_nx = (new_byte == 8'd0) ? CRC : PAYLOAD;
                PAYLOAD: if (byte_done && pay_last) state_nx = CRC;
                CRC:     if (bit_cnt == 5'd23) state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nx;
    end

    // Bit-level datapath: whitening, CRC, byte assembly, CRC compare
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            symbol_clk_q      <= 1'b0;
            packet_detected_q <= 1'b0;
            w                 <= '0;
            crc               <= '0;
            sreg              <= '0;
            len               <= '0;
            byte_cnt          <= '0;
            bit_cnt           <= '0;
            crc_match         <= 1'b0;
            pkt_done          <= 1'b0;
            crc_ok            <= 1'b0;
            overflow          <= 1'b0;
        end else begin
            symbol_clk_q      <= symbol_clk;
            packet_detected_q <= packet_detected;
            pkt_done          <= 1'b0;
            if (en && pd_start) begin
                w         <= {channel[0], channel[1], channel[2], channel[3],
                              channel[4], channel[5], 1'b1};
                crc       <= CRC_INIT;
                sreg      <= '0;
                byte_cnt  <= '0;
                bit_cnt   <= '0;
                crc_match <= 1'b1;
                crc_ok    <= 1'b0;
                overflow  <= 1'b0;
            end else begin
                if (drop) overflow <= 1'b1;
                if (adv) begin
                    w <= w_nx;
                    case (state)
                        HEADER: begin
                            crc     <= crc_nx;
                            sreg    <= new_byte[7:1];
                            bit_cnt <= hdr_done ? 5'd0 : bit_cnt + 5'd1;
                            if (hdr_done) len <= new_byte;
                        end
                        PAYLOAD: begin
                            crc     <= crc_nx;
                            sreg    <= new_byte[7:1];
                            bit_cnt <= byte_done ? 5'd0 : bit_cnt + 5'd1;
                            if (byte_done) byte_cnt <= byte_cnt + 8'd1;
                        end
                        CRC: begin
                            // crc is frozen here; received bits are compared MSB first.
                            if (d != crc[crc_idx]) crc_match <= 1'b0;
                            bit_cnt <= bit_cnt + 5'd1;
                            if (bit_cnt == 5'd23) begin
                                pkt_done <= 1'b1;
                                crc_ok   <= crc_match & (d == crc[0]);
                                bit_cnt  <= 5'd0;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // Output byte FIFO
    assign full       = (count == DEPTH);
    assign byte_valid = en & (count != '0);
    assign pop        = byte_valid & byte_ready;
    // A full FIFO still accepts a push when the head is popped in the same cycle.
    assign do_push    = push & (~full | pop);
    assign drop       = push & full & ~pop;
    assign byte_data  = mem[rd_ptr][7:0];
    assign byte_last  = mem[rd_ptr][8];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (!en) begin
            wr_ptr <= rd_ptr;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= {push_last, new_byte};
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (pop) rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: ;
            endcase
        end
    end

endmodule
